// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// UartCmdRx: UART receiver that buffers incoming bytes in a FIFO.
//
// The serial input is sampled 16 times per bit. Each accepted frame is pushed
// into a show-ahead FIFO, and the last accepted byte is mirrored on LED.
// Frame, parity and overrun errors set sticky flags until err_clr is pulsed.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line bit rate
//   DATA_BITS   payload bits per frame (5..8)
//   FIFO_DEPTH  receive buffer entries (power of two, >= 2)
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity builds only)
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   rx          asynchronous serial input, idle high
//   rd_en       pops the FIFO head (ignored while empty)
//   err_clr     clears all sticky error flags
//   rd_data     FIFO head, valid while empty is 0
//   empty/full  FIFO status (registered)
//   count       FIFO occupancy (registered)
//   frame_err   sticky: stop bit sampled low
//   parity_err  sticky: parity mismatch (tied 0 without parity)
//   overrun     sticky: frame accepted while FIFO was full and not popped
//   LED         last accepted byte, zero-extended
//
// Build option: define UART_CMD_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit.
// ---------------------------------------------------------------------------
module uart_cmd_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [7:0]                    LED
);

    // Rounded clocks per oversampling tick, never below one.
    localparam int TICK_DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int TICK_LIM = (TICK_DIV < 1) ? 1 : TICK_DIV;
    localparam int TICK_W   = $clog2(TICK_LIM + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

`ifdef UART_CMD_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic                 rxMeta_q, rxSync_q, rxPrev_q;
    logic [TICK_W-1:0]    tickCnt_q, tickCnt_d;
    logic                 tick;
    state_t               state_q, state_d;
    logic [3:0]           tickNum_q, tickNum_d;
    logic [2:0]           bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 waitHigh_q, waitHigh_d;
    logic                 accept, frameEvent, parityEvent, overrunEvent;
`ifdef UART_CMD_RX_PARITY_EN
    logic                 parBit_q, parBit_d;
    logic                 parityBad;
`endif

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 empty_q, empty_d, full_q, full_d;
    logic                 push, pop;
    logic                 frameErr_q, frameErr_d;
    logic                 parityErr_q, parityErr_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           led_q, led_d;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    // All three reset to idle-high so reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    assign tick = (tickCnt_q == TICK_W'(TICK_LIM - 1));

`ifdef UART_CMD_RX_PARITY_EN
    // Data ones plus parity bit must have the selected parity.
    assign parityBad = ((^shift_q) ^ parBit_q) != (PARITY_ODD != 0);
`endif

    // Receiver FSM. tickNum counts ticks within a bit; sampling happens on the
    // 8th tick after the start edge (mid start bit) and every 16th tick after.
    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tick ? '0 : tickCnt_q + TICK_W'(1);
        tickNum_d   = tick ? tickNum_q + 4'd1 : tickNum_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        waitHigh_d  = waitHigh_q;
        accept      = 1'b0;
        frameEvent  = 1'b0;
        parityEvent = 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
        parBit_d    = parBit_q;
`endif
        case (state_q)
            IDLE: begin
                waitHigh_d = 1'b0;
                if (rxPrev_q && !rxSync_q) begin
                    state_d   = START;
                    tickCnt_d = '0;
                    tickNum_d = '0;
                end
            end
            START: begin
                if (tick && tickNum_q == 4'd7) begin
                    tickNum_d = '0;
                    bitIdx_d  = '0;
                    state_d   = rxSync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tickNum_q == 4'd15) begin
                    shift_d  = {rxSync_q, shift_q[DATA_BITS-1:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_CMD_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_CMD_RX_PARITY_EN
            PARITY: begin
                if (tick && tickNum_q == 4'd15) begin
                    parBit_d = rxSync_q;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                // After a framing error, stay here until the line is idle
                // again so a held-low line cannot start a bogus frame.
                if (waitHigh_q) begin
                    if (rxSync_q) begin
                        waitHigh_d = 1'b0;
                        state_d    = IDLE;
                    end
                end else if (tick && tickNum_q == 4'd15) begin
                    if (!rxSync_q) begin
                        frameEvent = 1'b1;
                        waitHigh_d = 1'b1;
`ifdef UART_CMD_RX_PARITY_EN
                    end else if (parityBad) begin
                        parityEvent = 1'b1;
                        state_d     = IDLE;
`endif
                    end else begin
                        accept  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            tickNum_q  <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            waitHigh_q <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            parBit_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            tickNum_q  <= tickNum_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            waitHigh_q <= waitHigh_d;
`ifdef UART_CMD_RX_PARITY_EN
            parBit_q   <= parBit_d;
`endif
        end
    end

    // FIFO bookkeeping and sticky flags. A pop on a full FIFO frees the slot
    // for a frame accepted in the same cycle, so that case is not an overrun.
    always_comb begin
        push         = accept && (!full_q || rd_en);
        pop          = rd_en && !empty_q;
        overrunEvent = accept && full_q && !rd_en;
        wrPtr_d      = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d      = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d      = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(FIFO_DEPTH));

        // A new error in the same cycle as err_clr must survive the clear.
        frameErr_d  = err_clr ? 1'b0 : frameErr_q;
        parityErr_d = err_clr ? 1'b0 : parityErr_q;
        overrun_d   = err_clr ? 1'b0 : overrun_q;
        if (frameEvent) frameErr_d = 1'b1;
        if (parityEvent) parityErr_d = 1'b1;
        if (overrunEvent) overrun_d = 1'b1;

        led_d = accept ? 8'(shift_q) : led_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            frameErr_q  <= 1'b0;
            parityErr_q <= 1'b0;
            overrun_q   <= 1'b0;
            led_q       <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            frameErr_q  <= frameErr_d;
            parityErr_q <= parityErr_d;
            overrun_q   <= overrun_d;
            led_q       <= led_d;
        end
    end

    // Storage needs no reset; empty gates the meaning of rd_data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= shift_q;
        end
    end

    assign rd_data   = mem_q[rdPtr_q];
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
    assign LED       = led_q;
`ifdef UART_CMD_RX_PARITY_EN
    assign parity_err = parityErr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
